// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state type and saturation helper for the display arbiter
package display_pkg;

  localparam int DIGITS_W = 20;
  localparam logic [DIGITS_W-1:0] DISPLAY_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    LINGER = 2'd2
  } arb_state_t;

  // Anything above six decimal digits is pinned to 999999.
  function automatic logic [DIGITS_W-1:0] sat_digits(input logic [DIGITS_W-1:0] v);
    return (v > DISPLAY_MAX) ? DISPLAY_MAX : v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search: first set req bit at or after start, with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int             j;
  logic [IDW-1:0] cand;

  // Scan farthest offset first so the nearest hit to start overwrites the rest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      cand = IDW'(j);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the six-digit display with minimum hold and idle blanking
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int IDLE_CYCLES = 100_000_000,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ-1:0][DIGITS_W-1:0]   value,
  input  logic                             force_shutdown,
  output logic [N_REQ-1:0]                 grant,
  output logic [IDW-1:0]                   active_id,
  output logic [DIGITS_W-1:0]              digits,
  output logic                             shutdown
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);

  arb_state_t          state, state_d;
  logic [HW-1:0]       hold_cnt, hold_d;
  logic [IW-1:0]       idle_cnt, idle_d;
  logic [N_REQ-1:0]    grant_d;
  logic [IDW-1:0]      id_d;
  logic [DIGITS_W-1:0] digits_d;

  logic [IDW-1:0]      rr_start;
  logic                pick_found;
  logic [IDW-1:0]      pick_idx;
  logic [N_REQ-1:0]    owner_mask;
  logic [N_REQ-1:0]    pick_onehot;
  logic                others;

  assign rr_start    = (active_id == IDW'(N_REQ - 1)) ? '0 : active_id + IDW'(1);
  assign owner_mask  = N_REQ'(1) << active_id;
  assign pick_onehot = N_REQ'(1) << pick_idx;
  assign others      = |(req & ~owner_mask);

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req   (req),
    .start (rr_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    id_d     = active_id;
    digits_d = digits;
    hold_d   = hold_cnt;
    idle_d   = idle_cnt;
    case (state)
      IDLE, LINGER: begin
        if (pick_found) begin
          state_d  = SHOW;
          grant_d  = pick_onehot;
          id_d     = pick_idx;
          digits_d = sat_digits(value[pick_idx]);
          hold_d   = '0;
        end else if (state == LINGER) begin
          if (idle_cnt == IDLE_MAX) state_d = IDLE;
          else idle_d = idle_cnt + IW'(1);
        end
      end
      SHOW: begin
        // A waiting requester takes over on hold expiry, or at once if the owner lets go.
        if (others && (!req[active_id] || hold_cnt == HOLD_MAX)) begin
          grant_d  = pick_onehot;
          id_d     = pick_idx;
          digits_d = sat_digits(value[pick_idx]);
          hold_d   = '0;
        end else if (req[active_id]) begin
          digits_d = sat_digits(value[active_id]);
          if (hold_cnt != HOLD_MAX) hold_d = hold_cnt + HW'(1);
        end else begin
          state_d = LINGER;
          grant_d = '0;
          idle_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      active_id <= '0;
      digits    <= '0;
      shutdown  <= 1'b1;
      hold_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      active_id <= id_d;
      digits    <= digits_d;
      shutdown  <= (state_d == IDLE) | force_shutdown;
      hold_cnt  <= hold_d;
      idle_cnt  <= idle_d;
    end
  end

endmodule
